// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
//   ld_state_t    : frame parser state (IDLE, LEN, DATA, CHK)
//   SYNC_BYTE_DEF : default frame start marker
//   LEN_FULL      : LEN field value that means "whole memory"
package imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEN  = 2'd1,
        ST_DATA = 2'd2,
        ST_CHK  = 2'd3
    } ld_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         LEN_FIELD_W   = 8;
    localparam logic [7:0] LEN_FULL      = 8'h00;

endpackage

// File: rtl/imem_loader_checksum.sv
// loader_checksum: 8-bit modular accumulator for the frame payload.
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero the accumulator (start of a frame)
//   add        : accumulate add_data this cycle
//   add_data   : payload byte
//   test_data  : candidate checksum byte
//   is_zero    : (sum + test_data) mod 256 == 0, combinational
module loader_checksum (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] add_data,
    input  logic [7:0] test_data,
    output logic       is_zero
);

    logic [7:0] sum;
    logic [7:0] total;

    always_ff @(posedge clk) begin
        if (reset || clr)
            sum <= 8'h00;
        else if (add)
            sum <= sum + add_data;
    end

    // 8-bit result wraps naturally, giving the mod-256 test.
    assign total   = sum + test_data;
    assign is_zero = (total == 8'h00);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: parses a framed byte stream (SYNC, LEN, payload, CHK) and
// writes the payload into instruction memory from address 0, holding the
// processor in reset until a frame with a good checksum has landed.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_data    : byte stream from the source
//   in_ready            : always 1 except the cycle after reset
//   imem_we/addr/wdata  : registered instruction-memory write port
//   cpu_reset           : processor reset, high = held
//   busy                : frame in progress
//   load_done           : one-cycle pulse on a good frame
//   load_err            : sticky; set on bad checksum/timeout, cleared by SYNC
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         TIMEOUT   = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    // remaining needs one extra bit to hold 2^ADDR_W for LEN=0
    localparam int REM_W  = ADDR_W + 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr;
    logic [REM_W-1:0]  rem;
    logic [IDLE_W-1:0] idle_cnt;

    logic acc, timeout, cs_zero;
    logic sync_hit, len_hit, wr_fire, chk_good, chk_bad, tmo_abort;

    assign acc     = in_valid && in_ready;
    // idle_cnt is about to reach TIMEOUT with no byte arriving
    assign timeout = !acc && (idle_cnt == IDLE_W'(TIMEOUT - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (acc && in_data == SYNC_BYTE) state_d = ST_LEN;
            ST_LEN: begin
                if (acc)          state_d = ST_DATA;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_DATA: begin
                if (acc && rem == REM_W'(1)) state_d = ST_CHK;
                else if (timeout)            state_d = ST_IDLE;
            end
            ST_CHK: begin
                if (acc || timeout) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- outputs / strobes ----------------
    always_comb begin
        sync_hit  = (state_q == ST_IDLE) && acc && (in_data == SYNC_BYTE);
        len_hit   = (state_q == ST_LEN)  && acc;
        wr_fire   = (state_q == ST_DATA) && acc;
        chk_good  = (state_q == ST_CHK)  && acc && cs_zero;
        chk_bad   = (state_q == ST_CHK)  && acc && !cs_zero;
        tmo_abort = (state_q != ST_IDLE) && timeout;
        busy      = (state_q != ST_IDLE);
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            addr     <= '0;
            rem      <= '0;
            idle_cnt <= '0;
        end else begin
            if (state_q == ST_IDLE || acc)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;

            if (len_hit) begin
                addr <= '0;
                rem  <= (in_data == LEN_FULL) ? {1'b1, {ADDR_W{1'b0}}}
                                              : REM_W'(in_data);
            end else if (wr_fire) begin
                // wraps to 0 after the last word of a full-depth frame
                addr <= addr + 1'b1;
                rem  <= rem - 1'b1;
            end
        end
    end

    loader_checksum u_cs (
        .clk       (clk),
        .reset     (reset),
        .clr       (len_hit),
        .add       (wr_fire),
        .add_data  (in_data),
        .test_data (in_data),
        .is_zero   (cs_zero)
    );

    // ---------------- registered write port and flags ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 8'h00;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            in_ready  <= 1'b1;
            imem_we   <= wr_fire;
            load_done <= chk_good;
            if (wr_fire) begin
                imem_addr  <= addr;
                imem_wdata <= in_data;
            end
            if (sync_hit)      cpu_reset <= 1'b1;
            else if (chk_good) cpu_reset <= 1'b0;
            if (sync_hit)                  load_err <= 1'b0;
            else if (chk_bad || tmo_abort) load_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int TMO = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, imem_we, cpu_reset, busy, load_done, load_err;
    logic [7:0] imem_addr, imem_wdata;

    int checks = 0;
    int failures = 0;

    imem_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       rdy;
        logic       we;
        logic [7:0] a;
        logic [7:0] wd;
        logic       cpu;
        logic       bz;
        logic       dn;
        logic       er;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic rdy, logic we,
                                logic [7:0] a, logic [7:0] wd, logic cpu, logic bz,
                                logic dn, logic er);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.rdy = rdy; t.we = we; t.a = a; t.wd = wd;
        t.cpu = cpu; t.bz = bz; t.dn = dn; t.er = er;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Apply one cycle of input, then sample just after the edge.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        @(negedge clk);
        reset = r; in_valid = v; in_data = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {10'd0, in_ready, imem_we, imem_addr, imem_wdata,
                cpu_reset, busy, load_done, load_err};
    endfunction

    initial begin
        int bad;
        //              r  v  d      rdy we a      wd     cpu bz dn er
        vecs[0]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        vecs[2]  = mk(0, 1, 8'h3C, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0); // garbage
        vecs[3]  = mk(0, 1, 8'hA5, 1, 0, 8'h00, 8'h00, 1, 1, 0, 0); // good frame
        vecs[4]  = mk(0, 1, 8'h03, 1, 0, 8'h00, 8'h00, 1, 1, 0, 0);
        vecs[5]  = mk(0, 1, 8'h11, 1, 1, 8'h00, 8'h11, 1, 1, 0, 0);
        vecs[6]  = mk(0, 1, 8'h22, 1, 1, 8'h01, 8'h22, 1, 1, 0, 0);
        vecs[7]  = mk(0, 1, 8'h33, 1, 1, 8'h02, 8'h33, 1, 1, 0, 0);
        vecs[8]  = mk(0, 1, 8'h9A, 1, 0, 8'h02, 8'h33, 0, 0, 1, 0);
        vecs[9]  = mk(0, 0, 8'h00, 1, 0, 8'h02, 8'h33, 0, 0, 0, 0);
        vecs[10] = mk(0, 1, 8'hA5, 1, 0, 8'h02, 8'h33, 1, 1, 0, 0); // bad checksum
        vecs[11] = mk(0, 1, 8'h02, 1, 0, 8'h02, 8'h33, 1, 1, 0, 0);
        vecs[12] = mk(0, 1, 8'h01, 1, 1, 8'h00, 8'h01, 1, 1, 0, 0);
        vecs[13] = mk(0, 1, 8'h02, 1, 1, 8'h01, 8'h02, 1, 1, 0, 0);
        vecs[14] = mk(0, 1, 8'h00, 1, 0, 8'h01, 8'h02, 1, 0, 0, 1);
        vecs[15] = mk(0, 0, 8'h00, 1, 0, 8'h01, 8'h02, 1, 0, 0, 1);
        vecs[16] = mk(0, 1, 8'hA5, 1, 0, 8'h01, 8'h02, 1, 1, 0, 0); // err cleared
        vecs[17] = mk(0, 1, 8'h01, 1, 0, 8'h01, 8'h02, 1, 1, 0, 0);
        vecs[18] = mk(0, 1, 8'hA5, 1, 1, 8'h00, 8'hA5, 1, 1, 0, 0); // A5 as data
        vecs[19] = mk(0, 1, 8'h5B, 1, 0, 8'h00, 8'hA5, 0, 0, 1, 0);
        vecs[20] = mk(0, 0, 8'h00, 1, 0, 8'h00, 8'hA5, 0, 0, 0, 0);
        vecs[21] = mk(0, 1, 8'hA5, 1, 0, 8'h00, 8'hA5, 1, 1, 0, 0); // reset mid-frame
        vecs[22] = mk(0, 1, 8'h05, 1, 0, 8'h00, 8'hA5, 1, 1, 0, 0);
        vecs[23] = mk(0, 1, 8'h10, 1, 1, 8'h00, 8'h10, 1, 1, 0, 0);
        vecs[24] = mk(0, 1, 8'h20, 1, 1, 8'h01, 8'h20, 1, 1, 0, 0);
        vecs[25] = mk(1, 1, 8'h30, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
        vecs[26] = mk(0, 1, 8'hA5, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0); // not ready yet
        vecs[27] = mk(0, 1, 8'h77, 1, 0, 8'h00, 8'h00, 1, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].r, vecs[i].v, vecs[i].d);
            chk($sformatf("vec%0d", i), outs(),
                {10'd0, vecs[i].rdy, vecs[i].we, vecs[i].a, vecs[i].wd,
                 vecs[i].cpu, vecs[i].bz, vecs[i].dn, vecs[i].er});
        end

        // Timeout: A5 04 10 then silence.
        step(0, 1, 8'hA5);
        step(0, 1, 8'h04);
        step(0, 1, 8'h10);
        for (int i = 0; i < TMO - 1; i++) step(0, 0, 8'h00);
        chk("tmo_before", {29'd0, busy, load_err, cpu_reset}, {29'd0, 3'b101});
        step(0, 0, 8'h00);
        chk("tmo_fire", {29'd0, busy, load_err, cpu_reset}, {29'd0, 3'b011});
        step(0, 1, 8'hA5);
        chk("tmo_err_clr", {31'd0, load_err}, 32'd0);
        step(0, 1, 8'h01);
        step(0, 1, 8'h42);
        step(0, 1, 8'hBE);
        chk("tmo_recover", {29'd0, load_done, cpu_reset, load_err}, {29'd0, 3'b100});
        step(0, 0, 8'h00);

        // Full-depth frame: LEN=0, payload 00..FF, CHK=80.
        step(0, 1, 8'hA5);
        step(0, 1, 8'h00);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            step(0, 1, 8'(i));
            if (!(imem_we === 1'b1 && imem_addr === 8'(i) && imem_wdata === 8'(i)
                  && busy === 1'b1)) bad++;
        end
        chk("full_writes", 32'(bad), 32'd0);
        chk("full_last_addr", {24'd0, imem_addr}, 32'h0000_00FF);
        step(0, 1, 8'h80);
        chk("full_done", {28'd0, imem_we, load_done, cpu_reset, busy}, {28'd0, 4'b0100});
        step(0, 0, 8'h00);

        // Back-to-back frames with in_valid held high.
        step(0, 1, 8'hA5);
        chk("b2b_rise1", {31'd0, cpu_reset}, 32'd1);
        step(0, 1, 8'h02);
        step(0, 1, 8'h01);
        step(0, 1, 8'h02);
        step(0, 1, 8'hFD);
        chk("b2b_done1", {29'd0, load_done, cpu_reset, busy}, {29'd0, 3'b100});
        step(0, 1, 8'hA5);
        chk("b2b_rise2", {29'd0, load_done, cpu_reset, busy}, {29'd0, 3'b011});
        step(0, 1, 8'h01);
        step(0, 1, 8'h07);
        chk("b2b_write", {23'd0, imem_we, imem_addr, imem_wdata}, {23'd0, 1'b1, 8'h00, 8'h07});
        step(0, 1, 8'hF9);
        chk("b2b_done2", {28'd0, load_done, cpu_reset, busy, load_err}, {28'd0, 4'b1000});
        step(0, 0, 8'h00);
        chk("b2b_pulse_end", {31'd0, load_done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface that the pipelined processor's fetch stage reads from.
- Accepts a framed byte stream over a valid/ready handshake and writes the 8-bit instructions sequentially into instruction memory starting at address 0.
- Holds the processor in reset while loading and releases it only after a frame with a valid checksum.
- Sits beside the processor top level and drives the processor's reset input and the instruction-memory write port.

Parameters:
- ADDR_W, 8, instruction-memory address width (depth 2^ADDR_W).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1000, maximum idle cycles between bytes inside a frame before abort.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  source presents in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; a transfer occurs when in_valid && in_ready at the clk edge.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  8  instruction byte.
- cpu_reset  out  1  drives the processor reset; high means the processor is held.
- busy  out  1  frame in progress.
- load_done  out  1  one-cycle pulse on a good frame.
- load_err  out  1  sticky error flag; cleared by a new SYNC_BYTE or by reset.

Behaviour:
- Frame format: SYNC_BYTE, LEN, LEN payload bytes, CHK.
  - LEN=0 means 2^ADDR_W bytes.
  - The frame is valid when (sum of payload + CHK) mod 256 == 0.
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, busy=0, load_done=0, load_err=0, state=IDLE, counters=0.
- in_ready is 1 in every state except the reset cycle itself. The loader never back-pressures; the source sets the rate.
- States:
  - IDLE: accepted byte == SYNC_BYTE -> LEN, set cpu_reset=1, busy=1, clear load_err. Any other byte is discarded.
  - LEN: accepted byte -> remaining = (byte==0 ? 2^ADDR_W : byte), addr=0, sum=0 -> DATA.
  - DATA: each accepted byte is written to memory.
    - imem_we=1 for exactly one cycle, the cycle after acceptance (registered), with imem_addr = current addr and imem_wdata = byte.
    - Then addr++, sum += byte (8-bit wrap), remaining--.
    - When remaining reaches 0 -> CHK.
  - CHK: on the accepted byte, if (sum + byte)[7:0]==0 -> IDLE, cpu_reset=0 the next cycle, load_done pulses 1 cycle, busy=0. Otherwise -> IDLE, load_err=1, cpu_reset stays 1, busy=0.
- Timeout: in LEN/DATA/CHK, an idle counter is cleared on each accepted byte and increments otherwise. When it reaches TIMEOUT -> IDLE, load_err=1, cpu_reset stays 1, busy=0.
- SYNC_BYTE values inside LEN/DATA/CHK are ordinary data, with no resync.
- cpu_reset falls only after a good frame. It rises on any SYNC_BYTE accepted in IDLE, so reloading a running CPU is allowed.
- Address wrap: with LEN=0 the last write goes to 2^ADDR_W-1. addr is never exposed above that value.
- A partial frame leaves the written memory contents in place; there is no rollback, and cpu_reset remains asserted.
- Reset mid-frame: returns to the reset values in the next cycle. Any pending imem_we is dropped.
- Throughput: one byte per cycle. A back-to-back stream is legal, including SYNC of the next frame in the cycle right after CHK.

Decomposition:
- Shared package: state enum (IDLE, LEN, DATA, CHK), SYNC_BYTE default, frame-length constants.
- One natural sub-module, loader_checksum: an 8-bit accumulator with clear/add/zero-test.
- The FSM, counters and write register stay in imem_loader.

Test Plan:
- Good frame: A5, 03, 11, 22, 33, CHK=9A.
  - Writes (0,11), (1,22), (2,33), each imem_we one cycle after acceptance.
  - load_done pulses, cpu_reset 1->0, load_err=0.
- Bad checksum: A5, 02, 01, 02, CHK=00.
  - Writes at addresses 0 and 1 occur.
  - load_err=1, cpu_reset stays 1, no load_done.
- Timeout: A5, 04, 10, then in_valid=0 for TIMEOUT cycles.
  - load_err=1 at cycle TIMEOUT, state IDLE.
  - A following good frame clears load_err and releases cpu_reset.
- Full-depth frame: A5, 00, bytes 00..FF, CHK=80.
  - 256 writes, last at addr FF.
  - Payload containing A5 is written as data.
- Reset asserted during DATA after 2 of 5 bytes.
  - All outputs return to reset values the next cycle, including cpu_reset=1.
  - Garbage before A5 is ignored.
- Back-to-back: two good frames with no gap, and in_valid held high throughout.
  - Both load_done pulses occur.
  - cpu_reset rises on the second A5 and falls after the second CHK.
